// File: rtl/triangle_pwm_deadtime_pkg.sv
// triangle_pwm_deadtime_pkg: shared state encoding, direction type and dead-counter sizing
package triangle_pwm_deadtime_pkg;
  typedef enum logic [2:0] {
    ST_OFF,
    ST_HI,
    ST_DEAD_HL,
    ST_LO,
    ST_DEAD_LH
  } state_t;
  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;
  localparam int DEADTIME_DEF = 3;
  function automatic int dead_cnt_w(input int deadtime);
    return $clog2(deadtime + 1);
  endfunction
endpackage

// File: rtl/triangle_pwm_deadtime_if.sv
// triangle_pwm_deadtime_if: carrier/duty inputs and half-bridge outputs of the PWM stage
interface triangle_pwm_deadtime_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic [WIDTH-1:0] mod_in;
  logic [WIDTH-1:0] duty_in;
  logic             pwm_hi;
  logic             pwm_lo;
  logic             cycle_start;
  logic [WIDTH-1:0] duty_q;
  modport master (
    output enable, mod_in, duty_in,
    input  pwm_hi, pwm_lo, cycle_start, duty_q
  );
  modport slave (
    input  enable, mod_in, duty_in,
    output pwm_hi, pwm_lo, cycle_start, duty_q
  );
endinterface

// File: rtl/triangle_valley_detect.sv
// triangle_valley_detect: tracks carrier direction and flags the first rising sample after a descent
module triangle_valley_detect
  import triangle_pwm_deadtime_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] mod_in,
  output logic             valley
);
  logic [WIDTH-1:0] prev_mod_q, prev_mod_d;
  dir_t             dir_q, dir_d;
  logic             first_q, first_d;
  // Equal samples (plateaus) keep the last direction so no false valley appears
  always_comb begin
    prev_mod_d = mod_in;
    dir_d      = mod_in > prev_mod_q ? DIR_UP : mod_in < prev_mod_q ? DIR_DOWN : dir_q;
    first_d    = 1'b0;
    valley     = first_q | (dir_q == DIR_DOWN && mod_in > prev_mod_q);
  end
  // History registers; the first-sample flag forces a valley right after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_mod_q <= '0;
      dir_q      <= DIR_UP;
      first_q    <= 1'b1;
    end else begin
      prev_mod_q <= prev_mod_d;
      dir_q      <= dir_d;
      first_q    <= first_d;
    end
  end
endmodule

// File: rtl/triangle_pwm_deadtime.sv
// triangle_pwm_deadtime: carrier-vs-duty compare driving a complementary pair with dead time
module triangle_pwm_deadtime
  import triangle_pwm_deadtime_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int DEADTIME = DEADTIME_DEF
) (
  input logic                    clk,
  input logic                    reset,
  triangle_pwm_deadtime_if.slave bus
);
  localparam int            CW       = dead_cnt_w(DEADTIME);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DEADTIME - 1);
  logic             valley;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic             cmp_q, cmp_d;
  logic             cs_q, cs_d;
  logic             hi_q, hi_d;
  logic             lo_q, lo_d;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  triangle_valley_detect #(.WIDTH(WIDTH)) u_valley (
    .clk    (clk),
    .reset  (reset),
    .mod_in (bus.mod_in),
    .valley (valley)
  );
  // Duty is only re-latched at valleys; compare uses the duty applied before this edge
  always_comb begin
    duty_d = valley ? bus.duty_in : duty_q;
    cs_d   = valley;
    cmp_d  = bus.mod_in < duty_q;
  end
  // Dead-time FSM; a compare reversal inside a dead state restarts the opposite dead interval
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!bus.enable) begin
      state_d = ST_OFF;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = cmp_q ? ST_DEAD_LH : ST_DEAD_HL;
          cnt_d   = CNT_LOAD;
        end
        ST_HI: if (!cmp_q) begin
          state_d = ST_DEAD_HL;
          cnt_d   = CNT_LOAD;
        end
        ST_LO: if (cmp_q) begin
          state_d = ST_DEAD_LH;
          cnt_d   = CNT_LOAD;
        end
        ST_DEAD_HL: if (cmp_q) begin
          state_d = ST_DEAD_LH;
          cnt_d   = CNT_LOAD;
        end else if (cnt_q == '0) state_d = ST_LO;
        else cnt_d = cnt_q - 1'b1;
        ST_DEAD_LH: if (!cmp_q) begin
          state_d = ST_DEAD_HL;
          cnt_d   = CNT_LOAD;
        end else if (cnt_q == '0) state_d = ST_HI;
        else cnt_d = cnt_q - 1'b1;
        default: begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end
      endcase
    end
    hi_d = state_d == ST_HI;
    lo_d = state_d == ST_LO;
  end
  // Registered state and outputs; outputs mirror the registered state decode
  always_ff @(posedge clk) begin
    if (reset) begin
      duty_q  <= '0;
      cmp_q   <= 1'b0;
      cs_q    <= 1'b0;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
      state_q <= ST_OFF;
      cnt_q   <= '0;
    end else begin
      duty_q  <= duty_d;
      cmp_q   <= cmp_d;
      cs_q    <= cs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.pwm_hi      = hi_q;
  assign bus.pwm_lo      = lo_q;
  assign bus.cycle_start = cs_q;
  assign bus.duty_q      = duty_q;
endmodule
